// File: rtl/button_pulse_conditioner_pkg.sv
// Shared definitions for the button pulse conditioner: debounce FSM encoding and counter sizing.
package button_pulse_conditioner_pkg;

    localparam int unsigned CNT_W_MAX = 28;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_state_e;

    // Bits needed to hold counts up to max(deb, rep) - 1.
    function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned rep);
        int unsigned m;
        m = (deb > rep) ? deb : rep;
        if (m <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, four-state debounce FSM and a one-cycle accept strobe.
// Auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce
    import button_pulse_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic accept
);

    localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [W-1:0] DEB_LAST = W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(32'd1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [W-1:0] REP_LAST = W'(REPEAT_CYCLES - 32'd1);
`endif

    logic [1:0]   sync_r;
    logic         btn_s;
    btn_state_e   state_r;
    btn_state_e   state_s;
    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_s;

    assign btn_s = sync_r[1];

    // Synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    // FSM state and shared debounce/repeat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state, counter update and accept strobe.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        accept  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_s) begin
                    state_s = ST_DEB_PRESS;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_PRESSED;
                    cnt_s   = CNT_ZERO;
                    accept  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_s = ST_DEB_RELEASE;
                    cnt_s   = CNT_ZERO;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt_r == REP_LAST) begin
                        cnt_s  = CNT_ZERO;
                        accept = 1'b1;
                    end else begin
                        cnt_s  = cnt_r + CNT_ONE;
                    end
`else
                    state_s = ST_PRESSED;
`endif
                end
            end
            ST_DEB_RELEASE: begin
                // A high sample here is bounce on release: back to held, no new pulse.
                if (btn_s) begin
                    state_s = ST_PRESSED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces the "one" and "zero" buttons into registered single-cycle P1/P2 pulses; simultaneous
// accepts become a conflict pulse. Define BTN_AUTO_REPEAT_EN for auto-repeat while held.
module button_pulse_conditioner
    import button_pulse_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_p1,
    input  logic btn_p2,
    output logic P1,
    output logic P2,
    output logic conflict
);

    logic accept_p1_s;
    logic accept_p2_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_deb_p1 (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_p1),
        .accept (accept_p1_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_deb_p2 (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_p2),
        .accept (accept_p2_s)
    );

    // Output registers with conflict arbitration; outputs are mutually exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            P1       <= 1'b0;
            P2       <= 1'b0;
            conflict <= 1'b0;
        end else if (accept_p1_s && accept_p2_s) begin
            P1       <= 1'b0;
            P2       <= 1'b0;
            conflict <= 1'b1;
        end else begin
            P1       <= accept_p1_s;
            P2       <= accept_p2_s;
            conflict <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner: directed scenarios followed by random bounce,
// checked every cycle against a run-length reference model.
module tb_button_pulse_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_p1 = 1'b0;
    logic btn_p2 = 1'b0;
    logic P1;
    logic P2;
    logic conflict;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_p1   (btn_p1),
        .btn_p2   (btn_p2),
        .P1       (P1),
        .P2       (P2),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;
    bit done   = 1'b0;
    logic [2:0] exp_q[$];

    // Reference model: accepted level flips after DEB+1 consecutive disagreeing samples.
    bit lvl[2];
    int run[2];
    int hold[2];
    bit dly0[2];
    bit dly1[2];

    function automatic void model_clear();
        for (int b = 0; b < 2; b++) begin
            lvl[b] = 1'b0; run[b] = 0; hold[b] = 0; dly0[b] = 1'b0; dly1[b] = 1'b0;
        end
    endfunction

    function automatic bit model_step(int b, bit s);
        bit a;
        a = 1'b0;
        if (s != lvl[b]) begin
            run[b] = run[b] + 1;
            if (run[b] == int'(DEB) + 1) begin
                lvl[b]  = s;
                run[b]  = 0;
                hold[b] = 0;
                a       = s;
            end
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
            if (s) begin
                if (run[b] > 0) begin
                    hold[b] = 0;
                end else begin
                    hold[b] = hold[b] + 1;
                    if (hold[b] == int'(REP)) begin
                        a       = 1'b1;
                        hold[b] = 0;
                    end
                end
            end
`endif
            run[b] = 0;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        bit s0, s1, a0, a1;
        cycle = cycle + 1;
        if (reset) begin
            model_clear();
            exp_q.push_back(3'b000);
        end else begin
            s0 = dly1[0];
            s1 = dly1[1];
            dly1[0] = dly0[0]; dly0[0] = btn_p1;
            dly1[1] = dly0[1]; dly0[1] = btn_p2;
            a0 = model_step(0, s0);
            a1 = model_step(1, s1);
            if (a0 && a1) begin
                exp_q.push_back(3'b100);
            end else begin
                exp_q.push_back({1'b0, a1, a0});
            end
        end
    end

    // Monitor: compare {conflict, P2, P1} against the scoreboard once per cycle.
    always @(negedge clk) begin
        logic [2:0] exp_v;
        if (!done) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty cycle %0d: got %b required an expected entry",
                         cycle, {conflict, P2, P1});
            end else begin
                exp_v = exp_q.pop_front();
                if ({conflict, P2, P1} === exp_v) begin
                    passed = passed + 1;
                end else begin
                    $display("FAIL outputs cycle %0d: {conflict,P2,P1} got %b required %b",
                             cycle, {conflict, P2, P1}, exp_v);
                end
            end
        end
    end

    task automatic set_for(input bit p1, input bit p2, input int n);
        btn_p1 = p1;
        btn_p2 = p2;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        set_for(1'b0, 1'b0, 4);

        // Single long press, then release
        set_for(1'b1, 1'b0, 20);
        set_for(1'b0, 1'b0, 10);
        // Bouncing zero button
        for (int i = 0; i < 5; i++) begin
            set_for(1'b0, 1'b1, 2);
            set_for(1'b0, 1'b0, 2);
        end
        set_for(1'b0, 1'b0, 10);
        // Simultaneous press -> conflict
        set_for(1'b1, 1'b1, 10);
        set_for(1'b0, 1'b0, 10);
        // Reset mid-debounce with button still held
        set_for(1'b1, 1'b0, 4);
        reset = 1'b1;
        set_for(1'b1, 1'b0, 1);
        reset = 1'b0;
        set_for(1'b1, 1'b0, 15);
        set_for(1'b0, 1'b0, 10);
        // Sequence 1,1,0,0
        set_for(1'b1, 1'b0, 10); set_for(1'b0, 1'b0, 10);
        set_for(1'b1, 1'b0, 10); set_for(1'b0, 1'b0, 10);
        set_for(1'b0, 1'b1, 10); set_for(1'b0, 1'b0, 10);
        set_for(1'b0, 1'b1, 10); set_for(1'b0, 1'b0, 10);
        // Long hold (repeat pulses when enabled)
        set_for(1'b1, 1'b0, 30);
        set_for(1'b0, 1'b0, 10);
        // Staggered presses one cycle apart
        set_for(1'b1, 1'b0, 1);
        set_for(1'b1, 1'b1, 12);
        set_for(1'b0, 1'b0, 10);

        // Randomized bounce, holds and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                set_for(btn_p1, btn_p2, int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            set_for(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 14)));
        end

        set_for(1'b0, 1'b0, 15);
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
